// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI write slave: FSM states, burst encodings, response codes.
package axi_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_slave_wr_mem.sv
// Byte-enabled single-write-port memory with a combinational debug read port.
// Latency: write lands on the clock edge; read is combinational. No backpressure.
// Contents are deliberately not reset.
module axi_slave_wr_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (we && wstrb[i]) begin
                mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_slave_wr.sv
// AXI write slave, one outstanding burst, storing beats into a local byte-enabled memory.
// Latency: 1 cycle AW, awlen+1 cycles W, B held until bready; awready returns the cycle after B.
// Backpressure: only bready stalls (B held stable); AW blocked outside IDLE. Option: AXI_SLAVE_WR_RANGE_CHECK_EN.
module axi_slave_wr
    import axi_slave_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int IDX_W      = $clog2(MEM_DEPTH),
    localparam int LG_STRB    = $clog2(STRB_WIDTH)
) (
    input  logic                  sig_clock,
    input  logic                  sig_reset,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [IDX_W-1:0]      dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_rdata
);

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic                  err_q, err_d;
    logic                  live_q, live_d;
    logic                  last_beat, beat_ok, mem_we;
    logic [IDX_W-1:0]      mem_idx;

    // Dropping the upper word-index bits gives the modulo-depth wrap.
    assign mem_idx   = addr_q[LG_STRB +: IDX_W];
    assign last_beat = (cnt_q == len_q);

`ifdef AXI_SLAVE_WR_RANGE_CHECK_EN
    assign beat_ok = (addr_q[ADDR_WIDTH-1:LG_STRB] < (ADDR_WIDTH-LG_STRB)'(MEM_DEPTH));
`else
    assign beat_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        burst_d = burst_q;
        err_d   = err_q;
        live_d  = 1'b1;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // live_q keeps awready low until the first edge after reset release.
                awready = live_q;
                if (awvalid && live_q) begin
                    id_d    = awid;
                    addr_d  = awaddr;
                    len_d   = awlen;
                    size_d  = awsize;
                    burst_d = awburst;
                    cnt_d   = 8'd0;
                    err_d   = (awburst == BURST_WRAP) || (awburst == 2'b11)
                              || (awsize > 3'(LG_STRB));
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_we = beat_ok;
                    if (!beat_ok || (wlast != last_beat)) begin
                        err_d = 1'b1;
                    end
                    if (burst_q != BURST_FIXED) begin
                        addr_d = addr_q + (ADDR_WIDTH'(1) << size_q);
                    end
                    cnt_d = cnt_q + 8'd1;
                    if (last_beat) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sig_clock or negedge sig_reset) begin
        if (!sig_reset) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            err_q   <= err_d;
            live_q  <= live_d;
        end
    end

    assign bid   = id_q;
    assign bresp = ((state_q == ST_RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;

    axi_slave_wr_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (sig_clock),
        .we    (mem_we),
        .waddr (mem_idx),
        .wdata (wdata),
        .wstrb (wstrb),
        .raddr (dbg_addr),
        .rdata (dbg_rdata)
    );

endmodule

// File: tb/tb_axi_slave_wr.sv
// Scoreboard bench for axi_slave_wr: expected B responses queued at AW time, checked on bvalid.
module tb_axi_slave_wr;
    import axi_slave_pkg::*;

    localparam int ID_WIDTH   = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int MEM_DEPTH  = 256;

    logic                  sig_clock = 1'b0;
    logic                  sig_reset = 1'b0;
    logic [ID_WIDTH-1:0]   awid = '0;
    logic [ADDR_WIDTH-1:0] awaddr = '0;
    logic [7:0]            awlen = '0;
    logic [2:0]            awsize = '0;
    logic [1:0]            awburst = '0;
    logic                  awvalid = 1'b0;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata = '0;
    logic [3:0]            wstrb = '0;
    logic                  wlast = 1'b0;
    logic                  wvalid = 1'b0;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready = 1'b0;
    logic [7:0]            dbg_addr = '0;
    logic [DATA_WIDTH-1:0] dbg_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [5:0] exp_q [$];

    always #5 sig_clock = ~sig_clock;

    axi_slave_wr #(
        .ID_WIDTH   (ID_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) dut (
        .sig_clock (sig_clock),
        .sig_reset (sig_reset),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
        int t = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && t < 50) begin
            @(negedge sig_clock);
            t++;
        end
        if (t >= 50) chk("aw_timeout", 0, 1);
        exp_q.push_back({id, resp});
        @(negedge sig_clock);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int t = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        while (!wready && t < 50) begin
            @(negedge sig_clock);
            t++;
        end
        if (t >= 50) chk("w_timeout", 0, 1);
        @(negedge sig_clock);
        wvalid = 1'b0;
    endtask

    task automatic wait_b(input int hold);
        int t = 0;
        logic [5:0] e;
        bready = 1'b0;
        while (!bvalid && t < 50) begin
            @(negedge sig_clock);
            t++;
        end
        if (!bvalid) chk("b_timeout", 0, 1);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 1, 0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        chk("bid", bid, e[5:2]);
        chk("bresp", bresp, e[1:0]);
        for (int i = 0; i < hold; i++) begin
            @(negedge sig_clock);
            chk("b_hold_vld", bvalid, 1);
            chk("b_hold_id", bid, e[5:2]);
            chk("b_hold_resp", bresp, e[1:0]);
        end
        bready = 1'b1;
        @(negedge sig_clock);
        bready = 1'b0;
        chk("bvld_after_b", bvalid, 0);
        chk("awrdy_after_b", awready, 1);
    endtask

    task automatic rd(input string tag, input logic [7:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        #1;
        chk(tag, dbg_rdata, exp);
    endtask

    initial begin
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_bresp", bresp, 0);
        @(negedge sig_clock);
        @(negedge sig_clock);
        sig_reset = 1'b1;
        #1;
        chk("rel_awready_pre", awready, 0);
        @(posedge sig_clock);
        #1;
        chk("rel_awready", awready, 1);
        @(negedge sig_clock);

        // Single beat
        send_aw(4'd3, 32'h10, 8'd0, 3'd2, BURST_INCR, RESP_OKAY);
        send_w(32'hDEADBEEF, 4'hF, 1'b1);
        wait_b(0);
        rd("single_w4", 8'd4, 32'hDEADBEEF);

        // INCR burst with B held under bready low
        send_aw(4'd5, 32'h0, 8'd3, 3'd2, BURST_INCR, RESP_OKAY);
        for (int i = 1; i <= 4; i++) send_w(32'(i), 4'hF, i == 4);
        wait_b(5);
        for (int i = 0; i < 4; i++) rd("incr_w", 8'(i), 32'(i + 1));

        // FIXED burst with partial strobes onto a cleared word
        send_aw(4'd1, 32'h8, 8'd0, 3'd2, BURST_INCR, RESP_OKAY);
        send_w(32'h0, 4'hF, 1'b1);
        wait_b(0);
        send_aw(4'd2, 32'h8, 8'd1, 3'd2, BURST_FIXED, RESP_OKAY);
        send_w(32'hAAAAAAAA, 4'h1, 1'b0);
        send_w(32'hBBBBBBBB, 4'h2, 1'b1);
        wait_b(0);
        rd("fixed_w2", 8'd2, 32'h0000BBAA);
        rd("fixed_w3", 8'd3, 32'd4);

        // Early wlast: both beats still written
        send_aw(4'd4, 32'h20, 8'd1, 3'd2, BURST_INCR, RESP_SLVERR);
        send_w(32'h0000_1111, 4'hF, 1'b1);
        send_w(32'h0000_2222, 4'hF, 1'b0);
        wait_b(0);
        rd("early_w8", 8'd8, 32'h1111);
        rd("early_w9", 8'd9, 32'h2222);

        // Missing wlast, WRAP, reserved burst, oversize
        send_aw(4'd6, 32'h28, 8'd0, 3'd2, BURST_INCR, RESP_SLVERR);
        send_w(32'h77, 4'hF, 1'b0);
        wait_b(0);
        send_aw(4'd7, 32'h30, 8'd0, 3'd2, BURST_WRAP, RESP_SLVERR);
        send_w(32'h88, 4'hF, 1'b1);
        wait_b(0);
        send_aw(4'd8, 32'h34, 8'd0, 3'd2, 2'b11, RESP_SLVERR);
        send_w(32'h99, 4'hF, 1'b1);
        wait_b(0);
        send_aw(4'd9, 32'h38, 8'd0, 3'd3, BURST_INCR, RESP_SLVERR);
        send_w(32'hAB, 4'hF, 1'b1);
        wait_b(0);

        // Word index past the memory depth
`ifdef AXI_SLAVE_WR_RANGE_CHECK_EN
        send_aw(4'd10, 32'(MEM_DEPTH * 4), 8'd0, 3'd2, BURST_INCR, RESP_SLVERR);
        send_w(32'h5555AAAA, 4'hF, 1'b1);
        wait_b(0);
        rd("range_w0", 8'd0, 32'd1);
`else
        send_aw(4'd10, 32'(MEM_DEPTH * 4), 8'd0, 3'd2, BURST_INCR, RESP_OKAY);
        send_w(32'h5555AAAA, 4'hF, 1'b1);
        wait_b(0);
        rd("range_w0", 8'd0, 32'h5555AAAA);
`endif

        // A second AW presented mid-burst must be ignored
        send_aw(4'd11, 32'h50, 8'd1, 3'd2, BURST_INCR, RESP_OKAY);
        awid = 4'd12; awaddr = 32'h70; awlen = 8'd0; awvalid = 1'b1;
        #1;
        chk("aw_blocked_data", awready, 0);
        send_w(32'hC0C0, 4'hF, 1'b0);
        send_w(32'hC1C1, 4'hF, 1'b1);
        #1;
        chk("aw_blocked_resp", awready, 0);
        awvalid = 1'b0;
        wait_b(0);
        rd("ovl_w20", 8'd20, 32'hC0C0);
        rd("ovl_w21", 8'd21, 32'hC1C1);

        // Reset mid-burst abandons the transaction
        send_aw(4'd13, 32'h40, 8'd3, 3'd2, BURST_INCR, RESP_OKAY);
        void'(exp_q.pop_back());
        send_w(32'h11, 4'hF, 1'b0);
        send_w(32'h22, 4'hF, 1'b0);
        sig_reset = 1'b0;
        #1;
        chk("mid_rst_awready", awready, 0);
        chk("mid_rst_wready", wready, 0);
        chk("mid_rst_bvalid", bvalid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge sig_clock);
            chk("mid_rst_bvld_hold", bvalid, 0);
        end
        sig_reset = 1'b1;
        @(posedge sig_clock);
        #1;
        chk("mid_rel_awready", awready, 1);
        chk("mid_rel_bvalid", bvalid, 0);
        @(negedge sig_clock);
        rd("keep_w16", 8'd16, 32'h11);
        rd("keep_w17", 8'd17, 32'h22);
        send_aw(4'd14, 32'h60, 8'd0, 3'd2, BURST_INCR, RESP_OKAY);
        send_w(32'hFEEDF00D, 4'hF, 1'b1);
        wait_b(0);
        rd("post_rst_w24", 8'd24, 32'hFEEDF00D);
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
